// File: rtl/npu_sram_reader.sv
// Burst reader: streams length words from a 1-cycle-latency SRAM port into a
// small output FIFO, throttling reads so every returning word always has a free slot.
module npu_sram_reader #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     sram_address,
  output logic                  sram_chipselect,
  output logic                  sram_write,
  output logic [DATA_W/8-1:0]   sram_byteenable,
  output logic                  sram_clken,
  input  logic [DATA_W-1:0]     sram_readdata,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    issue_rem_q, issue_rem_d;
  logic [LEN_W-1:0]    out_rem_q, out_rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   data_q, data_d;
  logic                cs_q, cs_d;
  logic                inflight_q;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                push, pop, last_pop;

  // Next-state, counters, FIFO bookkeeping and registered-output decisions
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_rem_d = issue_rem_q;
    out_rem_d   = out_rem_q;
    done_d      = 1'b0;
    push        = inflight_q;
    pop         = valid_q & out_ready;
    last_pop    = pop & last_q;

    if (pop) begin
      out_rem_d = out_rem_q - LEN_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d     = S_READ;
            addr_d      = base_addr;
            issue_rem_d = length;
            out_rem_d   = length;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_READ: begin
        if (cs_q) begin
          addr_d      = addr_q + ADDR_W'(1);
          issue_rem_d = issue_rem_q - LEN_W'(1);
          if (issue_rem_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (last_pop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    valid_d  = (cnt_d != '0);
    last_d   = valid_d && (out_rem_d == LEN_W'(1));
    // A word pushed into an otherwise-empty FIFO lands directly at the head
    data_d   = (push && (wr_ptr_q == rd_ptr_d)) ? sram_readdata : mem_q[rd_ptr_d];
    // Next cycle's occupancy is cnt_d plus the read issued this cycle
    cs_d     = (state_d == S_READ) && (issue_rem_d != '0) &&
               ((32'(cnt_d) + 32'(cs_q)) < FIFO_DEPTH);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_rem_q <= '0;
      out_rem_q   <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      data_q      <= '0;
      cs_q        <= 1'b0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_rem_q <= issue_rem_d;
      out_rem_q   <= out_rem_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      data_q      <= data_d;
      cs_q        <= cs_d;
      inflight_q  <= cs_q;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sram_readdata;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign sram_address    = addr_q;
  assign sram_chipselect = cs_q;
  assign sram_write      = 1'b0;
  assign sram_byteenable = '1;
  assign sram_clken      = 1'b1;
  assign out_data        = data_q;
  assign out_valid       = valid_q;
  assign out_last        = last_q;

endmodule
